mem_port_arbiter: RTL

//  Shares the single unified instruction/data memory port between two requesters:

---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/rr_arb2.sv | 10 +
 rtl/mem_port_arbiter.sv | 83 ++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the unified memory port arbiter.
package mem_arb_pkg;
    typedef enum logic {ST_IDLE, ST_BUSY} arb_state_t;
    typedef enum logic {P0, P1} port_t;
    localparam int CNT_W = 4;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin grant; on a tie the port that did not win last time wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last,
    output logic [1:0] gnt
);
    assign gnt = (&req) ? ((last == P0) ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (p0) and load/store (p1),
// one transaction in flight, round-robin, fixed read latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    output logic          p0_gnt,
    output logic          p0_done,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_done,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    arb_state_t       state, state_nxt;
    port_t            last, port_l;
    logic             we_l, take, fin, busy;
    logic [AW-1:0]    addr_l;
    logic [DW-1:0]    wdata_l;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       g;

    rr_arb2 u_rr (.req({p1_req, p0_req}), .last(last), .gnt(g));

    // Grants are suppressed during reset so no request is accepted and then lost.
    assign busy = state == ST_BUSY;
    assign take = !busy && !rst && |g;
    assign fin  = busy && !rst && cnt == '0;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb state_nxt = take ? ST_BUSY : (fin ? ST_IDLE : state);

    always_ff @(posedge clk) begin
        if (rst) begin
            last    <= P0;
            port_l  <= P0;
            we_l    <= 1'b0;
            addr_l  <= '0;
            wdata_l <= '0;
            cnt     <= '0;
        end else if (take) begin
            last    <= port_t'(g[1]);
            port_l  <= port_t'(g[1]);
            we_l    <= g[1] & p1_we;
            addr_l  <= g[1] ? p1_addr : p0_addr;
            wdata_l <= g[1] ? p1_wdata : '0;
            cnt     <= (g[1] & p1_we) ? '0 : CNT_W'(MEM_LAT - 1);
        end else if (busy && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Writes occupy a single BUSY cycle, so mem_we is high exactly once per write.
    always_comb begin
        p0_gnt    = take & g[0];
        p1_gnt    = take & g[1];
        mem_addr  = busy ? addr_l : '0;
        mem_wdata = busy ? wdata_l : '0;
        mem_we    = busy & we_l;
        p0_done   = fin & (port_l == P0);
        p1_done   = fin & (port_l == P1);
        p0_rdata  = p0_done ? mem_rdata : '0;
        p1_rdata  = (p1_done & !we_l) ? mem_rdata : '0;
    end
endmodule
